// File: rtl/fft_pkg.sv
// Shared fixed-point FFT types and helpers: complex word, saturation and
// round-half-up arithmetic shifts on a wide signed accumulator.
package fft_pkg;

  localparam int unsigned FFT_DW = 16;
  localparam int unsigned FFT_TW = 16;
  localparam int unsigned ACC_W  = 64;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cpx_t;

  // Clamp v to the signed range of a w-bit word.
  function automatic logic signed [ACC_W-1:0] sat_to(input logic signed [ACC_W-1:0] v,
                                                     input int unsigned w);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W-1:0] v, input int unsigned w);
    return v != sat_to(v, w);
  endfunction

  // (v + 2^(sh-1)) >>> sh
  function automatic logic signed [ACC_W-1:0] rnd_shr(input logic signed [ACC_W-1:0] v,
                                                      input int unsigned sh);
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

endpackage

// File: rtl/r2sdf_stage_fx_if.sv
// Streaming sample bus of one R2SDF stage, including the twiddle ROM lookup.
interface r2sdf_stage_fx_if #(
  parameter int unsigned LOG2N = 3,
  parameter int unsigned DW    = 16,
  parameter int unsigned TW    = 16
);
  logic                    in_valid;
  logic                    in_start;
  logic                    inverse;
  logic signed [DW-1:0]    in_re;
  logic signed [DW-1:0]    in_im;
  logic [LOG2N-2:0]        tw_addr;
  logic signed [TW-1:0]    tw_cos;
  logic signed [TW-1:0]    tw_sin;
  logic                    out_valid;
  logic                    out_start;
  logic signed [DW-1:0]    out_re;
  logic signed [DW-1:0]    out_im;
  logic                    ovf;

  modport master (
    output in_valid, in_start, inverse, in_re, in_im, tw_cos, tw_sin,
    input  tw_addr, out_valid, out_start, out_re, out_im, ovf
  );

  modport slave (
    input  in_valid, in_start, inverse, in_re, in_im, tw_cos, tw_sin,
    output tw_addr, out_valid, out_start, out_re, out_im, ovf
  );
endinterface

// File: rtl/r2sdf_delay_line.sv
// Stall-aware feedback delay line: on an enabled beat the head word leaves
// and the pushed word enters, so a word re-emerges after DELAY beats.
module r2sdf_delay_line #(
  parameter int unsigned DELAY = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] push,
  output logic [W-1:0] head
);

  logic [DELAY-1:0][W-1:0] mem_q;
  logic [DELAY-1:0][W-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = push;
      for (int i = 1; i < int'(DELAY); i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  assign head = mem_q[DELAY-1];

endmodule

// File: rtl/r2sdf_stage_fx.sv
// Fixed-point radix-2 single-path delay-feedback DIF butterfly stage with
// per-stage scaling, stall tolerance, forward/inverse twiddles and sticky overflow.
module r2sdf_stage_fx
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = 3,
  parameter int unsigned STAGE = 1,
  parameter int unsigned DW    = 16,
  parameter int unsigned TW    = 16,
  parameter int unsigned SCALE = 1
) (
  input logic              clk,
  input logic              reset,
  r2sdf_stage_fx_if.slave  bus
);

  localparam int unsigned DELAY = 2 ** (LOG2N - STAGE);
  localparam int unsigned CW    = LOG2N - STAGE + 1;
  localparam int unsigned AW    = LOG2N - 1;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 armed_q, armed_d;
  logic                 primed_q, primed_d;
  logic                 inv_q, inv_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_start_q, out_start_d;
  logic signed [DW-1:0] out_re_q, out_re_d;
  logic signed [DW-1:0] out_im_q, out_im_d;

  logic                 start_beat, active, phase, inv_eff, sat_evt;
  logic [CW-1:0]        cnt_eff, j_w;
  logic [AW-1:0]        k;
  logic [2*DW-1:0]      head_w, push_w;
  logic signed [DW-1:0] hr, hi, o_re, o_im;

  logic signed [ACC_W-1:0] s_re, s_im, d_re, d_im;
  logic signed [ACC_W-1:0] s_re_v, s_im_v, d_re_v, d_im_v;
  logic signed [ACC_W-1:0] cosv, sinv, p_re, p_im;
  logic                    bf_sat, mul_sat;

  // Beat qualification, counter phase and twiddle index.
  always_comb begin
    start_beat = bus.in_valid & bus.in_start;
    active     = bus.in_valid & (armed_q | bus.in_start);
    cnt_eff    = start_beat ? '0 : cnt_q;
    phase      = cnt_eff[CW-1];
    j_w        = cnt_eff & CW'((1 << (CW - 1)) - 1);
    k          = phase ? '0 : AW'(32'(j_w) << (STAGE - 1));
    inv_eff    = start_beat ? bus.inverse : inv_q;
  end

  assign bus.tw_addr = k;

  r2sdf_delay_line #(
    .DELAY (DELAY),
    .W     (2 * DW)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .en    (active),
    .push  (push_w),
    .head  (head_w)
  );

  // Butterfly, complex multiplier and phase mux.
  always_comb begin
    hr   = head_w[2*DW-1:DW];
    hi   = head_w[DW-1:0];
    s_re = ACC_W'(hr) + ACC_W'(bus.in_re);
    s_im = ACC_W'(hi) + ACC_W'(bus.in_im);
    d_re = ACC_W'(hr) - ACC_W'(bus.in_re);
    d_im = ACC_W'(hi) - ACC_W'(bus.in_im);
    if (SCALE != 0) begin
      s_re_v = rnd_shr(s_re, 1);
      s_im_v = rnd_shr(s_im, 1);
      d_re_v = rnd_shr(d_re, 1);
      d_im_v = rnd_shr(d_im, 1);
      bf_sat = 1'b0;
    end else begin
      s_re_v = sat_to(s_re, DW);
      s_im_v = sat_to(s_im, DW);
      d_re_v = sat_to(d_re, DW);
      d_im_v = sat_to(d_im, DW);
      bf_sat = sat_hit(s_re, DW) | sat_hit(s_im, DW) | sat_hit(d_re, DW) | sat_hit(d_im, DW);
    end

    // W = cos - j*sin; the inverse transform conjugates it.
    cosv    = ACC_W'(bus.tw_cos);
    sinv    = inv_eff ? -ACC_W'(bus.tw_sin) : ACC_W'(bus.tw_sin);
    p_re    = rnd_shr(ACC_W'(hr) * cosv + ACC_W'(hi) * sinv, TW - 1);
    p_im    = rnd_shr(ACC_W'(hi) * cosv - ACC_W'(hr) * sinv, TW - 1);
    mul_sat = sat_hit(p_re, DW) | sat_hit(p_im, DW);

    if (phase) begin
      o_re    = DW'(s_re_v);
      o_im    = DW'(s_im_v);
      push_w  = {DW'(d_re_v), DW'(d_im_v)};
      sat_evt = active & bf_sat;
    end else if (k == '0) begin
      o_re    = hr;
      o_im    = hi;
      push_w  = {bus.in_re, bus.in_im};
      sat_evt = 1'b0;
    end else begin
      o_re    = DW'(sat_to(p_re, DW));
      o_im    = DW'(sat_to(p_im, DW));
      push_w  = {bus.in_re, bus.in_im};
      sat_evt = active & mul_sat;
    end
  end

  // Next state: nothing moves except on an armed input beat.
  always_comb begin
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    primed_d    = primed_q;
    inv_d       = inv_q;
    ovf_d       = ovf_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_valid_d = 1'b0;
    out_start_d = 1'b0;
    if (active) begin
      armed_d     = 1'b1;
      cnt_d       = cnt_eff + CW'(1);
      inv_d       = inv_eff;
      primed_d    = primed_q | phase;
      out_valid_d = primed_q | phase;
      out_start_d = phase & (j_w == '0);
      ovf_d       = (start_beat ? 1'b0 : ovf_q) | sat_evt;
      if (out_valid_d) begin
        out_re_d = o_re;
        out_im_d = o_im;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      primed_q    <= 1'b0;
      inv_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      primed_q    <= primed_d;
      inv_q       <= inv_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_start = out_start_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_r2sdf_stage_fx.sv
// Bench for an 8-point first stage: frame vectors with expected sums and
// twiddled diffs, a scoreboard queue, and reset/resync/overflow sequences.
module tb_r2sdf_stage_fx;

  typedef struct packed {
    logic [7:0][15:0] xr;
    logic [7:0][15:0] xi;
    logic [7:0][15:0] er;
    logic [7:0][15:0] ei;
    logic             inv;
    logic             sc;
    logic             stall;
    logic             junk;
    logic             ovf;
    logic [1:0]       tol;
  } vec_t;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               start;
    logic [1:0]         tol;
  } exp_t;

  localparam int NV = 10;

  logic clk;
  logic reset;
  logic in_valid, in_start, inverse;
  logic signed [15:0] in_re, in_im;
  logic chk_sel, stall;
  logic mon_valid, mon_start, mon_ovf;
  logic signed [15:0] mon_re, mon_im;

  int   errors = 0;
  int   checks = 0;
  int   n_valid = 0;
  exp_t expq[$];
  vec_t vecs[NV];

  r2sdf_stage_fx_if #(.LOG2N(3), .DW(16), .TW(16)) if0 ();
  r2sdf_stage_fx_if #(.LOG2N(3), .DW(16), .TW(16)) if1 ();

  r2sdf_stage_fx #(.LOG2N(3), .STAGE(1), .DW(16), .TW(16), .SCALE(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  r2sdf_stage_fx #(.LOG2N(3), .STAGE(1), .DW(16), .TW(16), .SCALE(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1));

  function automatic longint rom_cos(input int k);
    case (k)
      1:       return 23170;
      2:       return 0;
      3:       return -23170;
      default: return 32767;
    endcase
  endfunction

  function automatic longint rom_sin(input int k);
    case (k)
      1:       return 23170;
      2:       return 32767;
      3:       return 23170;
      default: return 0;
    endcase
  endfunction

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if0.in_start = in_start;  assign if1.in_start = in_start;
  assign if0.inverse  = inverse;   assign if1.inverse  = inverse;
  assign if0.in_re    = in_re;     assign if1.in_re    = in_re;
  assign if0.in_im    = in_im;     assign if1.in_im    = in_im;
  assign if0.tw_cos = 16'(rom_cos(int'(if0.tw_addr)));
  assign if0.tw_sin = 16'(rom_sin(int'(if0.tw_addr)));
  assign if1.tw_cos = 16'(rom_cos(int'(if1.tw_addr)));
  assign if1.tw_sin = 16'(rom_sin(int'(if1.tw_addr)));

  always_comb begin
    mon_valid = chk_sel ? if1.out_valid : if0.out_valid;
    mon_start = chk_sel ? if1.out_start : if0.out_start;
    mon_ovf   = chk_sel ? if1.ovf       : if0.ovf;
    mon_re    = chk_sel ? if1.out_re    : if0.out_re;
    mon_im    = chk_sel ? if1.out_im    : if0.out_im;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint sat16(input longint v, inout bit ov);
    if (v > 32767) begin ov = 1'b1; return 32767; end
    if (v < -32768) begin ov = 1'b1; return -32768; end
    return v;
  endfunction

  function automatic longint scl(input longint v, input bit sc, inout bit ov);
    if (sc) return (v + 1) >>> 1;
    return sat16(v, ov);
  endfunction

  // Frame-level reference: s_j = x_j + x_{j+4}; y_j = (x_j - x_{j+4}) * W8^j.
  function automatic vec_t golden(input vec_t v);
    vec_t   r;
    bit     ov;
    longint ar, ai, br, bi, dr, di, c, s, yr, yi;
    r  = v;
    ov = 1'b0;
    for (int j = 0; j < 4; j++) begin
      ar = longint'($signed(v.xr[j]));   ai = longint'($signed(v.xi[j]));
      br = longint'($signed(v.xr[j+4])); bi = longint'($signed(v.xi[j+4]));
      r.er[j] = 16'(scl(ar + br, v.sc, ov));
      r.ei[j] = 16'(scl(ai + bi, v.sc, ov));
      dr = scl(ar - br, v.sc, ov);
      di = scl(ai - bi, v.sc, ov);
      if (j == 0) begin
        yr = dr; yi = di;
      end else begin
        c  = rom_cos(j);
        s  = v.inv ? -rom_sin(j) : rom_sin(j);
        yr = sat16((dr * c + di * s + 16384) >>> 15, ov);
        yi = sat16((di * c - dr * s + 16384) >>> 15, ov);
      end
      r.er[j+4] = 16'(yr);
      r.ei[j+4] = 16'(yi);
    end
    r.ovf = ov;
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic push_exp(input logic [15:0] re, input logic [15:0] im, input bit st,
                          input logic [1:0] tol);
    exp_t e;
    e.re = re; e.im = im; e.start = st; e.tol = tol;
    expq.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    expq.delete();
  endtask

  task automatic beat(input bit st, input int re, input int im);
    if (stall) begin
      while ($urandom_range(1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1; in_start = st; in_re = 16'(re); in_im = 16'(im);
    @(posedge clk); #1;
    in_valid = 1'b0; in_start = 1'b0;
  endtask

  task automatic run_row(input vec_t v);
    do_reset();
    chk_sel = v.sc; stall = v.stall; inverse = v.inv;
    if (v.junk) begin
      beat(1'b1, 500, -300);
      beat(1'b0, 700, 200);
    end
    for (int i = 0; i < 8; i++) begin
      if (i >= 4) push_exp(v.er[i-4], v.ei[i-4], i == 4, v.tol);
      beat(i == 0, int'($signed(v.xr[i])), int'($signed(v.xi[i])));
    end
    for (int i = 0; i < 4; i++) begin
      push_exp(v.er[i+4], v.ei[i+4], 1'b0, v.tol);
      beat(1'b0, 0, 0);
    end
    repeat (3) @(negedge clk);
    chk("drain", longint'(expq.size()), 0);
    chk("ovf_end", longint'(mon_ovf), longint'(v.ovf));
  endtask

  initial begin
    int   tmp;
    int   nv0;
    exp_t e;
    longint dre, dim;

    reset = 1'b1; in_valid = 1'b0; in_start = 1'b0; inverse = 1'b0;
    in_re = '0; in_im = '0; chk_sel = 1'b0; stall = 1'b0;

    // Scoreboard monitor: each output beat must match the next expectation.
    fork
      forever begin
        @(negedge clk);
        if (!reset && mon_valid) begin
          n_valid++;
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got re=%0d im=%0d with no output expected", mon_re, mon_im);
          end else begin
            e   = expq.pop_front();
            dre = longint'(mon_re) - longint'(e.re);
            dim = longint'(mon_im) - longint'(e.im);
            if (dre < 0) dre = -dre;
            if (dim < 0) dim = -dim;
            if (dre > longint'(e.tol) || dim > longint'(e.tol) || mon_start != e.start) begin
              errors++;
              $display("FAIL out_sample: got re=%0d im=%0d start=%0b expected re=%0d im=%0d start=%0b",
                       mon_re, mon_im, mon_start, e.re, e.im, e.start);
            end
          end
        end
      end
    join_none

    // Vector table.
    for (int r = 0; r < NV; r++) vecs[r] = '0;
    vecs[0].xr[0] = 16'(1000);                          // impulse, full scale
    vecs[0].er[0] = 16'(1000); vecs[0].er[4] = 16'(1000);
    for (int i = 0; i < 8; i++) vecs[1].xr[i] = 16'(1000); // DC, scaled
    vecs[1].sc = 1'b1;
    for (int i = 0; i < 4; i++) vecs[1].er[i] = 16'(1000);
    vecs[2].xr[1] = 16'(16384);                          // twiddle k=1, forward
    vecs[2].er[1] = 16'(16384); vecs[2].er[5] = 16'(11585); vecs[2].ei[5] = 16'(-11585);
    vecs[2].tol = 2'd1;
    vecs[3] = vecs[2]; vecs[3].inv = 1'b1; vecs[3].ei[5] = 16'(11585);
    vecs[4].xr[0] = 16'(32767); vecs[4].xr[4] = 16'(32767); // saturating sum
    vecs[4].er[0] = 16'(32767); vecs[4].ovf = 1'b1;
    vecs[5] = vecs[0]; vecs[5].stall = 1'b1;             // impulse under stalls
    for (int i = 0; i < 8; i++) begin
      tmp = int'($urandom_range(16000)) - 8000; vecs[6].xr[i] = 16'(tmp);
      tmp = int'($urandom_range(16000)) - 8000; vecs[6].xi[i] = 16'(tmp);
      tmp = int'($urandom_range(65535)) - 32768; vecs[7].xr[i] = 16'(tmp);
      tmp = int'($urandom_range(65535)) - 32768; vecs[7].xi[i] = 16'(tmp);
    end
    vecs[6] = golden(vecs[6]);
    vecs[7].sc = 1'b1; vecs[7].inv = 1'b1; vecs[7] = golden(vecs[7]);
    vecs[8] = vecs[6]; vecs[8].inv = 1'b1; vecs[8].stall = 1'b1; vecs[8] = golden(vecs[8]);
    vecs[9] = vecs[0]; vecs[9].junk = 1'b1;              // mid-frame start resync

    // Reset state.
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", longint'(mon_valid), 0);
    chk("rst_out_start", longint'(mon_start), 0);
    chk("rst_out_re", longint'(mon_re), 0);
    chk("rst_out_im", longint'(mon_im), 0);
    chk("rst_ovf", longint'(mon_ovf), 0);

    for (int r = 0; r < NV; r++) run_row(vecs[r]);

    // Overflow holds through idle cycles and clears on the next start beat.
    run_row(vecs[4]);
    repeat (2) @(negedge clk);
    chk("ovf_hold", longint'(mon_ovf), 1);
    push_exp(16'(0), 16'(0), 1'b0, 2'd0);
    beat(1'b1, 0, 0);
    @(negedge clk);
    chk("ovf_clear_on_start", longint'(mon_ovf), 0);
    repeat (2) @(negedge clk);
    chk("ovf_seq_drain", longint'(expq.size()), 0);

    // Reset at beat 5 abandons the frame; unarmed beats produce nothing.
    do_reset();
    chk_sel = 1'b0; stall = 1'b0; inverse = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) push_exp(16'(1000), 16'(0), 1'b1, 2'd0);
      beat(i == 0, (i == 0) ? 1000 : 0, 0);
    end
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", longint'(mon_valid), 0);
    chk("midrst_out_start", longint'(mon_start), 0);
    chk("midrst_out_re", longint'(mon_re), 0);
    chk("midrst_out_im", longint'(mon_im), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    expq.delete();
    nv0 = n_valid;
    for (int i = 0; i < 8; i++) beat(1'b0, 500, 0);
    repeat (2) @(negedge clk);
    chk("unarmed_no_valid", longint'(n_valid - nv0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
